// File: rtl/networkadapter_conf_pkg.sv
// networkadapter_conf_pkg: register map, CONF bits, LFSR constants, response FSM type and system config for the NA config block
package networkadapter_conf_pkg;
  localparam logic [9:0] REG_TILEID         = 10'd0;
  localparam logic [9:0] REG_NUMTILES       = 10'd1;
  localparam logic [9:0] REG_CONF           = 10'd3;
  localparam logic [9:0] REG_COREBASE       = 10'd4;
  localparam logic [9:0] REG_CORES_PER_TILE = 10'd6;
  localparam logic [9:0] REG_GMEM_SIZE      = 10'd7;
  localparam logic [9:0] REG_GMEM_TILE      = 10'd8;
  localparam logic [9:0] REG_LMEM_SIZE      = 10'd9;
  localparam logic [9:0] REG_NUMCTS         = 10'd10;
  localparam logic [9:0] REG_SEED           = 10'd11;
  localparam logic [9:0] REG_EVT_STATUS     = 10'd12;
  localparam logic [9:0] REG_EVT_MASK       = 10'd13;
  localparam logic [9:0] REG_CYCLE_LO       = 10'd14;
  localparam logic [9:0] REG_CYCLE_HI       = 10'd15;
  localparam logic [9:0] REG_SCRATCH        = 10'h020;
  localparam logic [9:0] REG_CTLIST         = 10'h080;

  localparam int CONF_MPSIMPLE = 0;
  localparam int CONF_DMA      = 1;

  localparam int          LFSR_W    = 32;
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic {ST_IDLE, ST_RESP} resp_state_e;

  typedef struct packed {
    logic [31:0]             NUMTILES;
    logic [31:0]             NUMCTS;
    logic [255:0][15:0]      CTLIST;
    logic [31:0]             CORES_PER_TILE;
    logic [31:0]             GMEM_SIZE;
    logic [31:0]             GMEM_TILE;
    logic [31:0]             LMEM_SIZE;
    logic                    NA_ENABLE_MPSIMPLE;
    logic                    NA_ENABLE_DMA;
  } config_t;

  localparam config_t CONFIG_DEFAULT = '{
    NUMTILES: 32'd1, NUMCTS: 32'd1, CTLIST: '0, CORES_PER_TILE: 32'd1,
    GMEM_SIZE: 32'd0, GMEM_TILE: 32'd0, LMEM_SIZE: 32'h0000_8000,
    NA_ENABLE_MPSIMPLE: 1'b1, NA_ENABLE_DMA: 1'b1
  };
endpackage

// File: rtl/networkadapter_conf_regs_lfsr.sv
// na_conf_lfsr: 32-bit Galois LFSR that steps on demand and reloads (zero data restores the seed)
module na_conf_lfsr
  import networkadapter_conf_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED_INIT = 32'hACE1_2345,
  parameter logic [LFSR_W-1:0] TAPS      = LFSR_TAPS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_step,
  input  logic              i_load,
  input  logic [LFSR_W-1:0] i_data,
  output logic [LFSR_W-1:0] o_state
);
  logic [LFSR_W-1:0] r_state;

  if (SEED_INIT == '0) begin : g_seed_chk
    $error("na_conf_lfsr: SEED_INIT must be nonzero");
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= SEED_INIT;
    else if (i_load) r_state <= (i_data == '0) ? SEED_INIT : i_data;
    else if (i_step) r_state <= {1'b0, r_state[LFSR_W-1:1]} ^ (r_state[0] ? TAPS : '0);
  end

  assign o_state = r_state;
endmodule

// File: rtl/networkadapter_conf_regs.sv
// networkadapter_conf_regs: NA config/status register slave with error response, scratch, events/irq and LFSR seed.
// Define OPTIMSOC_NA_CONF_CYCLE_COUNTER_EN to add the 64-bit cycle counter behind CYCLE_LO/CYCLE_HI.
module networkadapter_conf_regs
  import networkadapter_conf_pkg::*;
#(
  parameter config_t     CONFIG      = CONFIG_DEFAULT,
  parameter logic [31:0] TILEID      = 32'd0,
  parameter logic [31:0] COREBASE    = 32'd0,
  parameter int          NUM_SCRATCH = 4,
  parameter int          NUM_EVENTS  = 8,
  parameter logic [31:0] SEED_INIT   = 32'hACE1_2345
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           wb_adr_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [3:0]            wb_sel_i,
  input  logic [31:0]           wb_dat_i,
  output logic [31:0]           wb_dat_o,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  output logic                  wb_rty_o,
  input  logic [NUM_EVENTS-1:0] event_i,
  output logic                  irq_o
);
  localparam int         SW      = (NUM_SCRATCH > 1) ? $clog2(NUM_SCRATCH) : 1;
  localparam logic [9:0] SCR_END = REG_SCRATCH + 10'(NUM_SCRATCH);

  if (NUM_SCRATCH < 1 || NUM_SCRATCH > 32) begin : g_scr_chk
    $error("NUM_SCRATCH out of range 1..32");
  end
  if (NUM_EVENTS < 1 || NUM_EVENTS > 32) begin : g_evt_chk
    $error("NUM_EVENTS out of range 1..32");
  end

  resp_state_e           r_state, w_state_nxt;
  logic                  r_ack, r_err, r_irq;
  logic [31:0]           r_dat;
  logic [NUM_EVENTS-1:0] r_status, r_mask, w_clr;
  logic [31:0]           r_scratch [NUM_SCRATCH];
  logic [9:0]            w_word;
  logic                  w_acc, w_hit, w_wr, w_rd, w_unused;
  logic [31:0]           w_rdata, w_bm, w_wd, w_seed, w_cyc_lo, w_cyc_hi;
  logic [7:0]            w_ct0, w_ct1;
  logic [15:0]           w_ent0, w_ent1;

  assign w_word   = wb_adr_i[11:2];
  assign w_acc    = (r_state == ST_IDLE) && wb_cyc_i && wb_stb_i;
  assign w_wr     = w_acc && w_hit && wb_we_i;
  assign w_rd     = w_acc && w_hit && !wb_we_i;
  assign w_bm     = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
  assign w_wd     = wb_dat_i & w_bm;
  assign w_unused = &{1'b0, wb_adr_i[1:0]};

  // Each CTLIST word packs two 16-bit entries; entries past NUMCTS are hidden.
  assign w_ct0  = {w_word[6:0], 1'b0};
  assign w_ct1  = {w_word[6:0], 1'b1};
  assign w_ent0 = ({24'd0, w_ct0} < CONFIG.NUMCTS) ? CONFIG.CTLIST[w_ct0] : 16'd0;
  assign w_ent1 = ({24'd0, w_ct1} < CONFIG.NUMCTS) ? CONFIG.CTLIST[w_ct1] : 16'd0;
  assign w_clr  = (w_wr && w_word == REG_EVT_STATUS) ? w_wd[NUM_EVENTS-1:0] : '0;

  always_comb begin
    w_hit   = 1'b1;
    w_rdata = 32'd0;
    if (wb_adr_i[15:12] != 4'd0) w_hit = 1'b0;
    else if (w_word[9:7] == REG_CTLIST[9:7]) w_rdata = {w_ent0, w_ent1};
    else if (w_word >= REG_SCRATCH && w_word < SCR_END) w_rdata = r_scratch[w_word[SW-1:0]];
    else
      case (w_word)
        REG_TILEID:         w_rdata = TILEID;
        REG_NUMTILES:       w_rdata = CONFIG.NUMTILES;
        REG_CONF: begin
          w_rdata[CONF_MPSIMPLE] = CONFIG.NA_ENABLE_MPSIMPLE;
          w_rdata[CONF_DMA]      = CONFIG.NA_ENABLE_DMA;
        end
        REG_COREBASE:       w_rdata = COREBASE;
        REG_CORES_PER_TILE: w_rdata = CONFIG.CORES_PER_TILE;
        REG_GMEM_SIZE:      w_rdata = CONFIG.GMEM_SIZE;
        REG_GMEM_TILE:      w_rdata = CONFIG.GMEM_TILE;
        REG_LMEM_SIZE:      w_rdata = CONFIG.LMEM_SIZE;
        REG_NUMCTS:         w_rdata = CONFIG.NUMCTS;
        REG_SEED:           w_rdata = w_seed;
        REG_EVT_STATUS:     w_rdata = 32'(r_status);
        REG_EVT_MASK:       w_rdata = 32'(r_mask);
        REG_CYCLE_LO:       w_rdata = w_cyc_lo;
        REG_CYCLE_HI:       w_rdata = w_cyc_hi;
        default:            w_hit   = 1'b0;
      endcase
  end

  always_comb w_state_nxt = (r_state == ST_IDLE && wb_cyc_i && wb_stb_i) ? ST_RESP : ST_IDLE;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
      r_dat    <= 32'd0;
      r_status <= '0;
      r_mask   <= '0;
      r_irq    <= 1'b0;
    end else begin
      r_ack    <= w_acc && w_hit;
      r_err    <= w_acc && !w_hit;
      if (w_acc) r_dat <= w_hit ? w_rdata : 32'd0;
      r_status <= (r_status & ~w_clr) | event_i;
      if (w_wr && w_word == REG_EVT_MASK)
        r_mask <= (r_mask & ~w_bm[NUM_EVENTS-1:0]) | w_wd[NUM_EVENTS-1:0];
      r_irq    <= |(r_status & r_mask);
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_SCRATCH; k++)
      if (rst) r_scratch[k] <= 32'd0;
      else if (w_wr && w_word == REG_SCRATCH + 10'(k)) r_scratch[k] <= (r_scratch[k] & ~w_bm) | w_wd;
  end

  na_conf_lfsr #(.SEED_INIT(SEED_INIT), .TAPS(LFSR_TAPS)) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .i_step  (w_rd && w_word == REG_SEED),
    .i_load  (w_wr && w_word == REG_SEED),
    .i_data  (wb_dat_i),
    .o_state (w_seed)
  );

`ifdef OPTIMSOC_NA_CONF_CYCLE_COUNTER_EN
  logic [63:0] r_cycle;
  logic [31:0] r_cyc_shadow;
  // Reading the low word snapshots the high word so a LO/HI pair is coherent.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cycle      <= 64'd0;
      r_cyc_shadow <= 32'd0;
    end else begin
      r_cycle <= r_cycle + 64'd1;
      if (w_rd && w_word == REG_CYCLE_LO) r_cyc_shadow <= r_cycle[63:32];
    end
  end
  assign w_cyc_lo = r_cycle[31:0];
  assign w_cyc_hi = r_cyc_shadow;
`else
  assign w_cyc_lo = 32'd0;
  assign w_cyc_hi = 32'd0;
`endif

  assign wb_dat_o = r_dat;
  assign wb_ack_o = r_ack;
  assign wb_err_o = r_err;
  assign wb_rty_o = 1'b0;
  assign irq_o    = r_irq;
endmodule

// File: tb/tb_networkadapter_conf_regs.sv
// tb_networkadapter_conf_regs: directed + randomized bus/event traffic checked each cycle against a transaction-level model
`timescale 1ns/1ps
module tb_networkadapter_conf_regs;
  import networkadapter_conf_pkg::*;

  localparam int          NE    = 8;
  localparam int          NS    = 4;
  localparam logic [31:0] TILE  = 32'd5;
  localparam logic [31:0] CBASE = 32'd10;
  localparam logic [31:0] SEED  = 32'd1;
  localparam config_t CFG = '{
    NUMTILES: 32'd4, NUMCTS: 32'd3,
    CTLIST: {{252{16'h0}}, 16'h7, 16'h4, 16'h2, 16'h0},
    CORES_PER_TILE: 32'd2, GMEM_SIZE: 32'h0100_0000, GMEM_TILE: 32'd3,
    LMEM_SIZE: 32'h0001_0000, NA_ENABLE_MPSIMPLE: 1'b1, NA_ENABLE_DMA: 1'b0
  };

  logic          clk = 1'b0, rst = 1'b1;
  logic [15:0]   wb_adr_i = '0;
  logic          wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
  logic [3:0]    wb_sel_i = '0;
  logic [31:0]   wb_dat_i = '0;
  logic [31:0]   wb_dat_o;
  logic          wb_ack_o, wb_err_o, wb_rty_o, irq_o;
  logic [NE-1:0] event_i = '0;

  always #5 clk = ~clk;

  networkadapter_conf_regs #(
    .CONFIG(CFG), .TILEID(TILE), .COREBASE(CBASE),
    .NUM_SCRATCH(NS), .NUM_EVENTS(NE), .SEED_INIT(SEED)
  ) dut (
    .clk(clk), .rst(rst), .wb_adr_i(wb_adr_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
    .wb_we_i(wb_we_i), .wb_sel_i(wb_sel_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o),
    .event_i(event_i), .irq_o(irq_o)
  );

  int errors = 0, checks = 0;
  bit chk_en = 1'b0, rnd_ev = 1'b0;

  logic [31:0]   m_scr [NS];
  logic [NE-1:0] m_status, m_mask;
  logic [31:0]   m_seed, m_shadow;
  logic [63:0]   m_cnt;
  bit            m_resp;
  logic          exp_ack = 1'b0, exp_err = 1'b0, exp_irq = 1'b0;
  logic [31:0]   exp_dat = '0;
  logic [15:0]   ct_tab [3] = '{16'h0, 16'h2, 16'h4};

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", nm, got, want, $time);
    end
  endtask

  function automatic logic [31:0] lfsr_next(input logic [31:0] x);
    return (x >> 1) ^ (x[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  function automatic logic [15:0] ct(input int n);
    return (n < 3) ? ct_tab[n] : 16'h0;
  endfunction

  task automatic model_read(input logic [15:0] adr, output bit hit, output logic [31:0] d);
    int w;
    w   = int'(adr[11:2]);
    hit = 1'b1;
    d   = 32'd0;
    if (adr[15:12] != 4'd0) hit = 1'b0;
    else if (w >= 128 && w < 256) d = {ct(2 * (w - 128)), ct(2 * (w - 128) + 1)};
    else if (w >= 32 && w < 32 + NS) d = m_scr[w - 32];
    else
      case (w)
        0:  d = TILE;
        1:  d = CFG.NUMTILES;
        3:  d = {30'd0, CFG.NA_ENABLE_DMA, CFG.NA_ENABLE_MPSIMPLE};
        4:  d = CBASE;
        6:  d = CFG.CORES_PER_TILE;
        7:  d = CFG.GMEM_SIZE;
        8:  d = CFG.GMEM_TILE;
        9:  d = CFG.LMEM_SIZE;
        10: d = CFG.NUMCTS;
        11: d = m_seed;
        12: d = 32'(m_status);
        13: d = 32'(m_mask);
`ifdef OPTIMSOC_NA_CONF_CYCLE_COUNTER_EN
        14: d = m_cnt[31:0];
        15: d = m_shadow;
`else
        14, 15: d = 32'd0;
`endif
        default: hit = 1'b0;
      endcase
  endtask

  // Advances the model over one clock edge using the inputs the DUT just sampled.
  task automatic model_step();
    bit hit;
    logic [31:0] d, bm;
    int w;
    if (rst) begin
      for (int i = 0; i < NS; i++) m_scr[i] = 32'd0;
      m_status = '0; m_mask = '0; m_seed = SEED; m_shadow = 32'd0; m_cnt = 64'd0;
      m_resp = 1'b0; exp_ack = 1'b0; exp_err = 1'b0; exp_irq = 1'b0; exp_dat = 32'd0;
      return;
    end
    bm = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
    w  = int'(wb_adr_i[11:2]);
    exp_irq = |(m_status & m_mask);
    if (m_resp) begin
      m_resp = 1'b0; exp_ack = 1'b0; exp_err = 1'b0;
    end else if (wb_cyc_i && wb_stb_i) begin
      model_read(wb_adr_i, hit, d);
      m_resp = 1'b1; exp_ack = hit; exp_err = !hit; exp_dat = hit ? d : 32'd0;
      if (hit && wb_we_i) begin
        if (w >= 32 && w < 32 + NS) m_scr[w - 32] = (m_scr[w - 32] & ~bm) | (wb_dat_i & bm);
        if (w == 11) m_seed = (wb_dat_i == 0) ? SEED : wb_dat_i;
        if (w == 12) m_status = m_status & ~NE'(wb_dat_i & bm);
        if (w == 13) m_mask = (m_mask & ~NE'(bm)) | NE'(wb_dat_i & bm);
      end else if (hit) begin
        if (w == 11) m_seed = lfsr_next(m_seed);
        if (w == 14) m_shadow = m_cnt[63:32];
      end
    end else begin
      exp_ack = 1'b0; exp_err = 1'b0;
    end
    m_status = m_status | event_i;
    m_cnt    = m_cnt + 64'd1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("ack", {31'd0, wb_ack_o}, {31'd0, exp_ack});
      check("err", {31'd0, wb_err_o}, {31'd0, exp_err});
      check("rty", {31'd0, wb_rty_o}, 32'd0);
      check("irq", {31'd0, irq_o}, {31'd0, exp_irq});
      if (exp_ack || exp_err) check("rdata", wb_dat_o, exp_dat);
    end
  end

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    event_i = rnd_ev ? NE'($urandom & $urandom) : '0;
  endtask

  task automatic bus(input logic we, input logic [15:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                     input logic [NE-1:0] ev, input bit hold,
                     output logic [31:0] rd, output logic ak, output logic er);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = dat; wb_sel_i = sel;
    event_i = event_i | ev;
    step();
    rd = wb_dat_o; ak = wb_ack_o; er = wb_err_o;
    if (!hold) begin wb_cyc_i = 1'b0; wb_stb_i = 1'b0; end
    step();
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
  endtask

  task automatic rd_chk(input string nm, input logic [15:0] adr, input logic [31:0] want, input bit want_err);
    logic [31:0] d;
    logic a, e;
    bus(1'b0, adr, 32'd0, 4'hF, '0, 1'b0, d, a, e);
    check({nm, "_dat"}, d, want);
    check({nm, "_resp"}, {30'd0, a, e}, want_err ? 32'd1 : 32'd2);
  endtask

  task automatic wr(input logic [15:0] adr, input logic [31:0] dat, input logic [3:0] sel, input logic [NE-1:0] ev);
    logic [31:0] d;
    logic a, e;
    bus(1'b1, adr, dat, sel, ev, 1'b0, d, a, e);
    check("wr_ack", {30'd0, a, e}, 32'd2);
  endtask

  initial begin
    logic [31:0] d, dat;
    logic a, e;
    int c;
    logic [9:0] w;
    logic [3:0] hi;
    step();
    chk_en = 1'b1;
    step();
    rst = 1'b0;
    check("rst_dat", wb_dat_o, 32'd0);
    check("rst_irq", {31'd0, irq_o}, 32'd0);

    rd_chk("tileid", 16'h0000, 32'd5, 1'b0);
    check("ack_drop", {31'd0, wb_ack_o}, 32'd0);
    rd_chk("err_hi", 16'h1000, 32'd0, 1'b1);
    rd_chk("err_w2", 16'h0008, 32'd0, 1'b1);
    wr(16'h0000, 32'hDEAD_BEEF, 4'hF, '0);
    rd_chk("tileid_ro", 16'h0000, 32'd5, 1'b0);
    rd_chk("conf", 16'h000C, 32'd1, 1'b0);
    rd_chk("ct0", 16'h0200, 32'h0000_0002, 1'b0);
    rd_chk("ct1", 16'h0204, 32'h0004_0000, 1'b0);
    rd_chk("ct_last", 16'h03FC, 32'd0, 1'b0);
    rd_chk("unmapped", 16'h0400, 32'd0, 1'b1);

    rd_chk("seed0", 16'h002C, 32'h0000_0001, 1'b0);
    rd_chk("seed1", 16'h002C, 32'h8020_0003, 1'b0);
    rd_chk("seed2", 16'h002C, 32'hC030_0002, 1'b0);
    wr(16'h002C, 32'd0, 4'hF, '0);
    rd_chk("seed_rld", 16'h002C, 32'h0000_0001, 1'b0);

    event_i = 8'h08;
    step();
    wr(16'h0034, 32'd8, 4'hF, '0);
    check("irq_set", {31'd0, irq_o}, 32'd1);
    wr(16'h0030, 32'd8, 4'hF, 8'h08);
    rd_chk("set_wins", 16'h0030, 32'd8, 1'b0);
    wr(16'h0030, 32'd8, 4'hF, '0);
    check("irq_clr", {31'd0, irq_o}, 32'd0);
    rd_chk("status0", 16'h0030, 32'd0, 1'b0);
    wr(16'h0034, 32'hFFFF_FFFF, 4'h1, '0);
    rd_chk("mask_w", 16'h0034, 32'h0000_00FF, 1'b0);

    wr(16'h0080, 32'h1122_3344, 4'hF, '0);
    wr(16'h0080, 32'hAABB_CCDD, 4'h5, '0);
    rd_chk("scr_sel", 16'h0080, 32'h11BB_33DD, 1'b0);
    rd_chk("scr_oob", 16'h0090, 32'd0, 1'b1);

`ifdef OPTIMSOC_NA_CONF_CYCLE_COUNTER_EN
    bus(1'b0, 16'h0038, 32'd0, 4'hF, '0, 1'b0, d, a, e);
    rd_chk("cyc_hi", 16'h003C, 32'd0, 1'b0);
`else
    rd_chk("cyc_lo", 16'h0038, 32'd0, 1'b0);
    rd_chk("cyc_hi", 16'h003C, 32'd0, 1'b0);
`endif

    bus(1'b0, 16'h0000, 32'd0, 4'hF, '0, 1'b1, d, a, e);
    check("hold_noack", {30'd0, wb_ack_o, wb_err_o}, 32'd0);

    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 16'h0; rst = 1'b1;
    step();
    check("rst_acc", {30'd0, wb_ack_o, wb_err_o}, 32'd0);
    rst = 1'b0;
    step();
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; rst = 1'b1;
    step();
    check("rst_resp", {30'd0, wb_ack_o, wb_err_o}, 32'd0);
    rst = 1'b0;
    rd_chk("scr_rst", 16'h0080, 32'd0, 1'b0);
    rd_chk("seed_rst", 16'h002C, 32'h0000_0001, 1'b0);

    rnd_ev = 1'b1;
    for (int i = 0; i < 600; i++) begin
      c  = $urandom_range(0, 9);
      hi = 4'd0;
      case (c)
        0, 1, 2, 3: w = 10'($urandom_range(0, 15));
        4:          w = 10'($urandom_range(32, 36));
        5:          w = 10'($urandom_range(128, 255));
        6:          w = 10'($urandom_range(256, 1023));
        7: begin
          w  = 10'($urandom_range(0, 15));
          hi = 4'($urandom_range(1, 15));
        end
        8:          w = 10'($urandom_range(11, 13));
        default:    w = 10'($urandom_range(16, 31));
      endcase
      dat = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      bus(1'($urandom_range(0, 1)), {hi, w, 2'($urandom)}, dat, 4'($urandom), '0,
          1'($urandom_range(0, 1)), d, a, e);
      repeat ($urandom_range(0, 2)) begin
        wb_stb_i = 1'($urandom);
        step();
      end
      wb_stb_i = 1'b0;
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
      end
    end
    rnd_ev = 1'b0;
    step();
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
